// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the sram_bank memory bank.
// Sequencer state encoding, byte-lane count and per-byte even parity.
package sram_bank_pkg;

  typedef enum logic [1:0] {CLEAR, DONE, RUN} seq_state_e;

  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

  // Callers zero-extend their word to MAX_DW and keep the low NB result bits.
  function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DW-1:0] data);
    logic [MAX_NB-1:0] p;
    for (int i = 0; i < MAX_NB; i++) p[i] = ^data[8*i +: 8];
    return p;
  endfunction

endpackage

// File: rtl/sram_bank_init_seq.sv
// Clear-on-reset sequencer: walks every word address writing zero, then
// raises ready. With INIT_CLR=0 it goes straight to RUN.
module sram_bank_init_seq
  import sram_bank_pkg::*;
#(
  parameter int AW       = 14,
  parameter int INIT_CLR = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          ready_o
);

  localparam seq_state_e RST_STATE = (INIT_CLR != 0) ? CLEAR : RUN;

  seq_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q;

  // ready is registered so it stays low through reset even when the
  // sequencer resets straight into RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = DONE;
      end
      DONE:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    clr_we_o   = (state_q == CLEAR);
    clr_addr_o = cnt_q;
    ready_o    = ready_q;
  end

endmodule

// File: rtl/sram_bank.sv
// Parametrised single-port SRAM bank with write-first reads, optional output
// register and clear-on-reset. Define SRAM_BANK_PARITY_EN for per-byte parity.
module sram_bank
  import sram_bank_pkg::*;
#(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int OUT_REG  = 0,
  parameter int INIT_CLR = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CS,
  input  logic [AW-1:0]   ADDR,
  input  logic [DW-1:0]   WDATA,
  input  logic [DW/8-1:0] WREN,
  output logic [DW-1:0]   RDATA,
  output logic            RVALID,
  output logic            READY,
  output logic            PERR
);

  localparam int NB    = nbytes(DW);
  localparam int DEPTH = 2 ** AW;
`ifdef SRAM_BANK_PARITY_EN
  localparam int MW = DW + NB;
`else
  localparam int MW = DW;
`endif

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          acc;
  logic          we;
  logic [AW-1:0] waddr;
  logic [MW-1:0] old_w;
  logic [MW-1:0] wword;
  logic [DW-1:0] merged_d;
  logic          perr_d;

  logic [MW-1:0] mem_q [DEPTH];

  sram_bank_init_seq #(
    .AW       (AW),
    .INIT_CLR (INIT_CLR)
  ) u_seq (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .ready_o    (READY)
  );

  assign acc = CS & READY;

`ifdef SRAM_BANK_PARITY_EN
  logic [MAX_DW-1:0] pbuf;
  logic [MAX_NB-1:0] pchk;
  logic [NB-1:0]     mpar;
`endif

  // Read-modify-merge: the stored word is merged with the enabled write lanes
  // so the same word feeds both the array write and the read return.
  always_comb begin
    old_w = mem_q[ADDR];
    for (int i = 0; i < NB; i++)
      merged_d[8*i +: 8] = WREN[i] ? WDATA[8*i +: 8] : old_w[8*i +: 8];
    perr_d = 1'b0;
`ifdef SRAM_BANK_PARITY_EN
    pbuf           = '0;
    pbuf[DW-1:0]   = merged_d;
    pchk           = byte_parity(pbuf);
    for (int i = 0; i < NB; i++)
      mpar[i] = WREN[i] ? pchk[i] : old_w[DW+i];
    perr_d = acc && (pchk[NB-1:0] != mpar);
    // Even parity of an all-zero byte is zero, so a clear word is all zeros.
    wword  = clr_we ? '0 : {mpar, merged_d};
`else
    wword  = clr_we ? '0 : merged_d;
`endif
    we    = clr_we | (acc & (|WREN));
    waddr = clr_we ? clr_addr : ADDR;
  end

  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wword;
  end

  // Stage p0: registered read return, zeroed when no access completes.
  logic [DW-1:0] rdata_p0_q;
  logic          vld_p0_q;
  logic          perr_p0_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p0_q   <= 1'b0;
      rdata_p0_q <= '0;
      perr_p0_q  <= 1'b0;
    end else begin
      vld_p0_q   <= acc;
      rdata_p0_q <= acc ? merged_d : '0;
      perr_p0_q  <= perr_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Stage p1: optional output register.
      logic [DW-1:0] rdata_p1_q;
      logic          vld_p1_q;
      logic          perr_p1_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          vld_p1_q   <= 1'b0;
          rdata_p1_q <= '0;
          perr_p1_q  <= 1'b0;
        end else begin
          vld_p1_q   <= vld_p0_q;
          rdata_p1_q <= rdata_p0_q;
          perr_p1_q  <= perr_p0_q;
        end
      end

      assign RVALID = vld_p1_q;
      assign RDATA  = rdata_p1_q;
      assign PERR   = perr_p1_q;
    end else begin : g_no_out_reg
      assign RVALID = vld_p0_q;
      assign RDATA  = rdata_p0_q;
      assign PERR   = perr_p0_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_bank.sv
// Directed self-checking bench for sram_bank: three instances cover
// latency-1 / latency-2 / wide no-clear configurations.
module tb_sram_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cs0 = 1'b0, rv0, rdy0, pe0;
  logic [3:0]  addr0 = '0, wr0 = '0;
  logic [31:0] wd0 = '0, rd0;

  logic        cs1 = 1'b0, rv1, rdy1, pe1;
  logic [3:0]  addr1 = '0, wr1 = '0;
  logic [31:0] wd1 = '0, rd1;

  logic        cs2 = 1'b0, rv2, rdy2, pe2;
  logic [5:0]  addr2 = '0;
  logic [7:0]  wr2 = '0;
  logic [63:0] wd2 = '0, rd2;

  sram_bank #(.AW(4), .DW(32), .OUT_REG(0), .INIT_CLR(1)) dut0 (
    .CLK(clk), .RST(rst), .CS(cs0), .ADDR(addr0), .WDATA(wd0), .WREN(wr0),
    .RDATA(rd0), .RVALID(rv0), .READY(rdy0), .PERR(pe0));

  sram_bank #(.AW(4), .DW(32), .OUT_REG(1), .INIT_CLR(1)) dut1 (
    .CLK(clk), .RST(rst), .CS(cs1), .ADDR(addr1), .WDATA(wd1), .WREN(wr1),
    .RDATA(rd1), .RVALID(rv1), .READY(rdy1), .PERR(pe1));

  sram_bank #(.AW(6), .DW(64), .OUT_REG(0), .INIT_CLR(0)) dut2 (
    .CLK(clk), .RST(rst), .CS(cs2), .ADDR(addr2), .WDATA(wd2), .WREN(wr2),
    .RDATA(rd2), .RVALID(rv2), .READY(rdy2), .PERR(pe2));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic acc0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we,
                      input logic [31:0] exp, input logic eperr, input string tag);
    @(negedge clk);
    cs0 = 1'b1; addr0 = a; wd0 = d; wr0 = we;
    @(negedge clk);
    cs0 = 1'b0; wr0 = '0;
    check({tag, ".vld"},  64'(rv0), 64'd1);
    check({tag, ".data"}, 64'(rd0), 64'(exp));
    check({tag, ".perr"}, 64'(pe0), 64'(eperr));
    @(negedge clk);
    check({tag, ".vld0"},  64'(rv0), 64'd0);
    check({tag, ".data0"}, 64'(rd0), 64'd0);
  endtask

  task automatic acc1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we,
                      input logic [31:0] exp, input string tag);
    @(negedge clk);
    cs1 = 1'b1; addr1 = a; wd1 = d; wr1 = we;
    @(negedge clk);
    cs1 = 1'b0; wr1 = '0;
    check({tag, ".early"}, 64'(rv1), 64'd0);
    @(negedge clk);
    check({tag, ".vld"},  64'(rv1), 64'd1);
    check({tag, ".data"}, 64'(rd1), 64'(exp));
  endtask

  task automatic acc2(input logic [5:0] a, input logic [63:0] d, input logic [7:0] we,
                      input logic [63:0] exp, input string tag);
    @(negedge clk);
    cs2 = 1'b1; addr2 = a; wd2 = d; wr2 = we;
    @(negedge clk);
    cs2 = 1'b0; wr2 = '0;
    check({tag, ".vld"},  64'(rv2), 64'd1);
    check({tag, ".data"}, rd2, exp);
    @(negedge clk);
    check({tag, ".vld0"}, 64'(rv2), 64'd0);
  endtask

  initial begin
    int r0, r1, r2;
    logic rvbad;

    // Reset state and READY timing for all three configurations.
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.rdata0",  64'(rd0),  64'd0);
    check("rst.rvalid0", 64'(rv0),  64'd0);
    check("rst.ready0",  64'(rdy0), 64'd0);
    check("rst.perr0",   64'(pe0),  64'd0);
    check("rst.ready2",  64'(rdy2), 64'd0);
    check("rst.rvalid1", 64'(rv1),  64'd0);
    rst = 1'b0;
    r0 = 0; r1 = 0; r2 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy0 && r0 == 0) r0 = k;
      if (rdy1 && r1 == 0) r1 = k;
      if (rdy2 && r2 == 0) r2 = k;
    end
    check("ready_lat0", 64'(r0), 64'd17);
    check("ready_lat1", 64'(r1), 64'd17);
    check("ready_lat2", 64'(r2), 64'd1);

    // Cleared array reads zero; WDATA ignored when WREN is zero.
    for (int i = 0; i < 16; i++)
      acc0(4'(i), 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "clr_rd");

    // Byte-lane merge with write-first return.
    acc0(4'd3, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0, "wr_full");
    acc0(4'd3, 32'h1122_3344, 4'b0101, 32'hDE22_BE44, 1'b0, "wr_lanes");
    acc0(4'd3, 32'h0,         4'b0000, 32'hDE22_BE44, 1'b0, "rd_lanes");
    acc0(4'd2, 32'h0,         4'b0000, 32'h0,         1'b0, "rd_nbr2");
    acc0(4'd4, 32'h0,         4'b0000, 32'h0,         1'b0, "rd_nbr4");

`ifdef SRAM_BANK_PARITY_EN
    acc0(4'd9, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5, 1'b0, "par_wr");
    @(negedge clk);
    dut0.mem_q[9][0] = ~dut0.mem_q[9][0];
    acc0(4'd9, 32'h0, 4'h0, 32'hA5A5_A5A4, 1'b1, "par_bad");
    acc0(4'd8, 32'h0, 4'h0, 32'h0,         1'b0, "par_ok");
`endif

    // Latency-2 instance: back-to-back reads with no bubbles.
    acc1(4'd1, 32'h1111_1111, 4'hF, 32'h1111_1111, "w1");
    acc1(4'd2, 32'h2222_2222, 4'hF, 32'h2222_2222, "w2");
    acc1(4'd3, 32'h3333_3333, 4'hF, 32'h3333_3333, "w3");
    @(negedge clk);
    check("b2b.pre_v", 64'(rv1), 64'd0);
    cs1 = 1'b1; addr1 = 4'd1; wr1 = 4'h0;
    @(negedge clk);
    check("b2b.lat_v", 64'(rv1), 64'd0);
    check("b2b.lat_d", 64'(rd1), 64'd0);
    addr1 = 4'd2;
    @(negedge clk);
    check("b2b.v1", 64'(rv1), 64'd1);
    check("b2b.d1", 64'(rd1), 64'h1111_1111);
    addr1 = 4'd3;
    @(negedge clk);
    cs1 = 1'b0;
    check("b2b.v2", 64'(rv1), 64'd1);
    check("b2b.d2", 64'(rd1), 64'h2222_2222);
    @(negedge clk);
    check("b2b.v3", 64'(rv1), 64'd1);
    check("b2b.d3", 64'(rd1), 64'h3333_3333);
    @(negedge clk);
    check("b2b.post_v", 64'(rv1), 64'd0);
    check("b2b.post_d", 64'(rd1), 64'd0);

    // Wide instance: single top lane write at the last address.
    acc2(6'd63, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF, "w64_full");
    acc2(6'd63, 64'hFF00_0000_0000_0000, 8'h80, 64'hFF23_4567_89AB_CDEF, "w64_lane7");
    acc2(6'd63, 64'h0,                   8'h00, 64'hFF23_4567_89AB_CDEF, "r64");

    // Reset mid-clear, then accesses during CLEAR/DONE must be dropped.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    check("midclr.ready", 64'(rdy0), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r0 = 0; rvbad = 1'b0;
    addr0 = 4'd5; wd0 = 32'hCAFE_F00D; wr0 = 4'hF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy0 && r0 == 0) r0 = k;
      if (rv0) rvbad = 1'b1;
      cs0 = (k >= 10 && k <= 16);
    end
    cs0 = 1'b0; wr0 = '0;
    check("rerst.ready_lat", 64'(r0), 64'd17);
    check("rerst.no_rvalid", 64'(rvbad), 64'd0);
    acc0(4'd5, 32'h0, 4'h0, 32'h0, 1'b0, "rerst.rd5");
    acc0(4'd3, 32'h0, 4'h0, 32'h0, 1'b0, "rerst.rd3");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
